// File: rtl/ram_pkg.sv
// Shared types and helpers for the two-port byte-writable data RAM.
package ram_pkg;

  typedef enum logic {
    RAM_INIT  = 1'b0,
    RAM_READY = 1'b1
  } ram_state_t;

  // Widest word the byte-merge helper handles; callers cast to and from it.
  localparam int unsigned RAM_MAX_DW = 1024;
  localparam int unsigned RAM_MAX_BE = RAM_MAX_DW / 8;

  // Byte-lane count for a given word width.
  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Per-byte mux: lane i takes new_word when be[i] is set, else old_word.
  function automatic logic [RAM_MAX_DW-1:0] merge_bytes(
    input logic [RAM_MAX_DW-1:0] old_word,
    input logic [RAM_MAX_DW-1:0] new_word,
    input logic [RAM_MAX_BE-1:0] be
  );
    logic [RAM_MAX_DW-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < RAM_MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_2p_init_if.sv
// Request/response signals of both RAM ports.
interface ram_2p_init_if
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  localparam int unsigned BE_WIDTH = be_width(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_ren;
  logic [BE_WIDTH-1:0]   a_wen;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_rvalid;

  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_ren;
  logic [BE_WIDTH-1:0]   b_wen;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_rvalid;

  modport master (
    output a_addr, a_wdata, a_ren, a_wen,
    output b_addr, b_wdata, b_ren, b_wen,
    input  a_rdata, a_rvalid, b_rdata, b_rvalid
  );

  modport slave (
    input  a_addr, a_wdata, a_ren, a_wen,
    input  b_addr, b_wdata, b_ren, b_wen,
    output a_rdata, a_rvalid, b_rdata, b_rvalid
  );

endinterface

// File: rtl/ram_init_ctrl.sv
// Clear-on-reset sequencer: walks every word once, then reports ready.
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned DATA_NUM       = 1024,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  srst_n,
  output logic                  clear_en,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  ready
);

  // One extra bit so DATA_NUM == 2**ADDR_WIDTH still terminates.
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam ram_state_t  RESET_STATE = CLEAR_ON_RESET ? RAM_INIT : RAM_READY;

  ram_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;

  // State, counter and ready registers.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next state: leave INIT on the edge that writes the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = (state_q == RAM_READY);
    case (state_q)
      RAM_INIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_NUM - 1)) state_d = RAM_READY;
      end
      RAM_READY: state_d = RAM_READY;
      default:   state_d = RESET_STATE;
    endcase
  end

  assign clear_en   = (state_q == RAM_INIT);
  assign clear_addr = cnt_q[ADDR_WIDTH-1:0];
  assign ready      = ready_q;

endmodule

// File: rtl/ram_2p_init.sv
// Two-port byte-writable RAM with write-first forwarding and hardware clear.
module ram_2p_init
  import ram_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH     = 32,
  parameter int unsigned          DATA_NUM       = 1024,
  parameter int unsigned          ADDR_WIDTH     = 10,
  parameter bit                   CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic clk,
  input  logic srst_n,
  output logic ready,
  ram_2p_init_if.slave bus
);

  localparam int unsigned BE_WIDTH = be_width(DATA_WIDTH);
  localparam int unsigned IDX_W    = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int unsigned CMP_W    = ADDR_WIDTH + 1;

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_WIDTH-1:0]   be
  );
    return DATA_WIDTH'(merge_bytes(RAM_MAX_DW'(old_word), RAM_MAX_DW'(new_word),
                                   RAM_MAX_BE'(be)));
  endfunction

  logic                  clear_en;
  logic [ADDR_WIDTH-1:0] clear_addr;

  ram_init_ctrl #(
    .DATA_NUM      (DATA_NUM),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_init_ctrl (
    .clk       (clk),
    .srst_n    (srst_n),
    .clear_en  (clear_en),
    .clear_addr(clear_addr),
    .ready     (ready)
  );

  logic [DATA_WIDTH-1:0] mem [DATA_NUM];

  logic                  a_in, b_in, a_wr, b_wr, a_rd, b_rd, same_addr;
  logic [IDX_W-1:0]      a_idx, b_idx;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_final, b_final;

  // Range check, gating and merged word seen by each port (B applied, then A).
  always_comb begin
    a_in      = {1'b0, bus.a_addr} < CMP_W'(DATA_NUM);
    b_in      = {1'b0, bus.b_addr} < CMP_W'(DATA_NUM);
    a_idx     = IDX_W'(bus.a_addr);
    b_idx     = IDX_W'(bus.b_addr);
    a_wr      = ready & a_in & (|bus.a_wen);
    b_wr      = ready & b_in & (|bus.b_wen);
    a_rd      = ready & bus.a_ren;
    b_rd      = ready & bus.b_ren;
    same_addr = (bus.a_addr == bus.b_addr);
    a_old     = a_in ? mem[a_idx] : '0;
    b_old     = b_in ? mem[b_idx] : '0;
    a_final   = merge_word(merge_word(a_old, bus.b_wdata,
                                      (b_wr && same_addr) ? bus.b_wen : '0),
                           bus.a_wdata, a_wr ? bus.a_wen : '0);
    b_final   = merge_word(merge_word(b_old, bus.b_wdata, b_wr ? bus.b_wen : '0),
                           bus.a_wdata, (a_wr && same_addr) ? bus.a_wen : '0);
  end

  // Array writes: clear sequence, else both ports (one write on a shared address).
  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem[IDX_W'(clear_addr)] <= INIT_VALUE;
    end else begin
      if (a_wr) mem[a_idx] <= a_final;
      if (b_wr && !(a_wr && same_addr)) mem[b_idx] <= b_final;
    end
  end

  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic                  a_rvalid_q, b_rvalid_q;

  // Registered read responses; out-of-range reads return zero.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_rd;
      b_rvalid_q <= b_rd;
      if (a_rd) a_rdata_q <= a_in ? a_final : '0;
      if (b_rd) b_rdata_q <= b_in ? b_final : '0;
    end
  end

  assign bus.a_rdata  = a_rdata_q;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.b_rvalid = b_rvalid_q;

endmodule

// File: tb/tb_ram_2p_init.sv
// Bench for ram_2p_init: three configurations, directed table plus random vs. model.
module tb_ram_2p_init;

  typedef struct packed {
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic        a_ren;
    logic [3:0]  a_wen;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata;
    logic        b_ren;
    logic [3:0]  b_wen;
  } req_t;

  typedef struct {
    req_t        r;
    logic [31:0] ea;
    logic        eva;
    logic [31:0] eb;
    logic        evb;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  logic rdy0, rdy1, rdy2;
  req_t drv [3];

  int checks = 0;
  int errors = 0;

  ram_2p_init_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4))  if0 ();
  ram_2p_init_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) if1 ();
  ram_2p_init_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4))  if2 ();

  assign if0.a_addr = 4'(drv[0].a_addr);  assign if0.b_addr = 4'(drv[0].b_addr);
  assign if0.a_wdata = drv[0].a_wdata;    assign if0.b_wdata = drv[0].b_wdata;
  assign if0.a_ren = drv[0].a_ren;        assign if0.b_ren = drv[0].b_ren;
  assign if0.a_wen = drv[0].a_wen;        assign if0.b_wen = drv[0].b_wen;
  assign if1.a_addr = drv[1].a_addr;      assign if1.b_addr = drv[1].b_addr;
  assign if1.a_wdata = drv[1].a_wdata;    assign if1.b_wdata = drv[1].b_wdata;
  assign if1.a_ren = drv[1].a_ren;        assign if1.b_ren = drv[1].b_ren;
  assign if1.a_wen = drv[1].a_wen;        assign if1.b_wen = drv[1].b_wen;
  assign if2.a_addr = 4'(drv[2].a_addr);  assign if2.b_addr = 4'(drv[2].b_addr);
  assign if2.a_wdata = drv[2].a_wdata;    assign if2.b_wdata = drv[2].b_wdata;
  assign if2.a_ren = drv[2].a_ren;        assign if2.b_ren = drv[2].b_ren;
  assign if2.a_wen = drv[2].a_wen;        assign if2.b_wen = drv[2].b_wen;

  ram_2p_init #(.DATA_WIDTH(32), .DATA_NUM(16), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b1),
                .INIT_VALUE(32'hDEADBEEF))
    dut0 (.clk(clk), .srst_n(rst0), .ready(rdy0), .bus(if0));
  ram_2p_init #(.DATA_WIDTH(32), .DATA_NUM(1000), .ADDR_WIDTH(10), .CLEAR_ON_RESET(1'b1),
                .INIT_VALUE(32'h0))
    dut1 (.clk(clk), .srst_n(rst1), .ready(rdy1), .bus(if1));
  ram_2p_init #(.DATA_WIDTH(32), .DATA_NUM(16), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b0),
                .INIT_VALUE(32'h0))
    dut2 (.clk(clk), .srst_n(rst2), .ready(rdy2), .bus(if2));

  // Reference model: memory contents and last returned word per port.
  logic [31:0] mdl [3][1024];
  logic [31:0] last_a [3];
  logic [31:0] last_b [3];
  int unsigned num [3] = '{16, 1000, 16};

  function automatic req_t mk(input logic [9:0] aa, input logic [31:0] aw, input logic ar,
                              input logic [3:0] ae, input logic [9:0] ba,
                              input logic [31:0] bw, input logic br, input logic [3:0] be);
    req_t r;
    r.a_addr = aa; r.a_wdata = aw; r.a_ren = ar; r.a_wen = ae;
    r.b_addr = ba; r.b_wdata = bw; r.b_ren = br; r.b_wen = be;
    return r;
  endfunction

  function automatic vec_t mkv(input req_t r, input logic [31:0] ea, input logic eva,
                               input logic [31:0] eb, input logic evb);
    vec_t v;
    v.r = r; v.ea = ea; v.eva = eva; v.eb = eb; v.evb = evb;
    return v;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void mem_write(input int d, input logic [9:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] wen);
    logic [31:0] w;
    if (wen == 4'b0 || int'(addr) >= int'(num[d])) return;
    w = mdl[d][addr];
    for (int i = 0; i < 4; i++) if (wen[i]) w[8*i +: 8] = wdata[8*i +: 8];
    mdl[d][addr] = w;
  endfunction

  // Both writes land (A last, so A owns shared lanes); reads see the post-write memory.
  function automatic void model_step(input int d, input req_t r,
                                     output logic [31:0] ea, output logic eva,
                                     output logic [31:0] eb, output logic evb);
    mem_write(d, r.b_addr, r.b_wdata, r.b_wen);
    mem_write(d, r.a_addr, r.a_wdata, r.a_wen);
    if (r.a_ren) last_a[d] = (int'(r.a_addr) < int'(num[d])) ? mdl[d][r.a_addr] : 32'h0;
    if (r.b_ren) last_b[d] = (int'(r.b_addr) < int'(num[d])) ? mdl[d][r.b_addr] : 32'h0;
    ea = last_a[d]; eva = r.a_ren;
    eb = last_b[d]; evb = r.b_ren;
  endfunction

  task automatic sample(input int d, output logic [31:0] ra, output logic va,
                        output logic [31:0] rb, output logic vb, output logic rdy);
    case (d)
      0: begin ra = if0.a_rdata; va = if0.a_rvalid; rb = if0.b_rdata; vb = if0.b_rvalid; rdy = rdy0; end
      1: begin ra = if1.a_rdata; va = if1.a_rvalid; rb = if1.b_rdata; vb = if1.b_rvalid; rdy = rdy1; end
      default: begin ra = if2.a_rdata; va = if2.a_rvalid; rb = if2.b_rdata; vb = if2.b_rvalid; rdy = rdy2; end
    endcase
  endtask

  // One request cycle; expectations from the table when use_tbl, else from the model.
  task automatic do_step(input int d, input req_t r, input string tag,
                         input bit use_tbl, input vec_t v);
    logic [31:0] ra, rb, ea, eb;
    logic va, vb, eva, evb, rdy;
    @(negedge clk);
    drv[d] = r;
    @(posedge clk);
    #1;
    sample(d, ra, va, rb, vb, rdy);
    drv[d] = '0;
    model_step(d, r, ea, eva, eb, evb);
    if (use_tbl) begin
      ea = v.ea; eva = v.eva; eb = v.eb; evb = v.evb;
    end
    chk($sformatf("%s d%0d a_rdata", tag, d), ra, ea);
    chk($sformatf("%s d%0d a_rvalid", tag, d), 32'(va), 32'(eva));
    chk($sformatf("%s d%0d b_rdata", tag, d), rb, eb);
    chk($sformatf("%s d%0d b_rvalid", tag, d), 32'(vb), 32'(evb));
  endtask

  function automatic logic [9:0] rnd_addr(input int d);
    if ($urandom_range(0, 1) == 0) return 10'($urandom_range(0, 3));
    return (d == 1) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
  endfunction

  function automatic logic [3:0] rnd_wen();
    if ($urandom_range(0, 2) == 0) return 4'b0;
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic rnd_steps(input int d, input int n);
    vec_t dummy;
    req_t r;
    dummy = mkv('0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < n; i++) begin
      r = mk(rnd_addr(d), $urandom, 1'($urandom_range(0, 1)), rnd_wen(),
             rnd_addr(d), $urandom, 1'($urandom_range(0, 1)), rnd_wen());
      do_step(d, r, "rnd", 1'b0, dummy);
    end
  endtask

  vec_t tbl [11];

  initial begin
    logic [31:0] ra, rb;
    logic va, vb, rdy;
    vec_t dummy;
    req_t junk;
    int t;

    dummy = mkv('0, '0, 1'b0, '0, 1'b0);
    junk  = mk(10'd2, 32'h55555555, 1'b1, 4'hF, 10'd9, 32'hAAAAAAAA, 1'b1, 4'hF);
    for (int d = 0; d < 3; d++) begin
      drv[d] = '0; last_a[d] = '0; last_b[d] = '0;
    end
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Reset state of every instance.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      sample(d, ra, va, rb, vb, rdy);
      chk($sformatf("reset d%0d ready", d), 32'(rdy), 32'h0);
      chk($sformatf("reset d%0d rvalid", d), 32'({va, vb}), 32'h0);
      chk($sformatf("reset d%0d rdata", d), ra | rb, 32'h0);
    end

    // First release; abort dut0's clear at INIT cycle 8.
    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drv[0] = junk;
      @(posedge clk);
      #1;
      chk($sformatf("init1 k%0d ready", k), 32'(rdy0), 32'h0);
      chk($sformatf("init1 k%0d rvalid", k), 32'({if0.a_rvalid, if0.b_rvalid}), 32'h0);
      if (k == 0) chk("noclear ready after first edge", 32'(rdy2), 32'h1);
      @(negedge clk);
    end
    drv[0] = '0;
    rst0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("midinit reset ready", 32'(rdy0), 32'h0);
    rst0 = 1'b1;

    // Second release: ready exactly after edge 16, requests meanwhile ignored.
    for (int k = 0; k <= 16; k++) begin
      drv[0] = (k < 16) ? junk : '0;
      @(posedge clk);
      #1;
      chk($sformatf("init2 k%0d ready", k), 32'(rdy0), (k == 16) ? 32'h1 : 32'h0);
      chk($sformatf("init2 k%0d rvalid", k), 32'({if0.a_rvalid, if0.b_rvalid}), 32'h0);
      chk($sformatf("init2 k%0d rdata", k), if0.a_rdata | if0.b_rdata, 32'h0);
      @(negedge clk);
    end
    drv[0] = '0;

    // dut0: cleared contents, then random traffic.
    for (int i = 0; i < 16; i++) mdl[0][i] = 32'hDEADBEEF;
    do_step(0, mk(10'd7, '0, 1'b1, 4'h0, 10'd2, '0, 1'b1, 4'h0), "clr7_2", 1'b1,
            mkv('0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1));
    do_step(0, mk(10'd15, '0, 1'b1, 4'h0, 10'd9, '0, 1'b1, 4'h0), "clr15_9", 1'b1,
            mkv('0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1));
    rnd_steps(0, 300);

    // dut2: fill every word, then back-to-back reads on distinct addresses.
    for (int i = 0; i < 8; i++)
      do_step(2, mk(10'(2*i), $urandom, 1'b0, 4'hF, 10'(2*i+1), $urandom, 1'b0, 4'hF),
              "fill", 1'b0, dummy);
    for (int i = 0; i < 40; i++) begin
      logic [9:0] aa, ba;
      aa = 10'($urandom_range(0, 15));
      ba = 10'((int'(aa) + $urandom_range(1, 15)) % 16);
      do_step(2, mk(aa, '0, 1'b1, 4'h0, ba, '0, 1'b1, 4'h0), "b2b", 1'b0, dummy);
    end
    rnd_steps(2, 100);

    // dut1: wait for the 1000-word clear with a bounded budget.
    t = 0;
    while (!rdy1 && t < 1200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("dut1 ready within budget", 32'(rdy1), 32'h1);
    for (int i = 0; i < 1024; i++) mdl[1][i] = 32'h0;

    tbl[0]  = mkv(mk(10'd3, 32'h11223344, 1'b0, 4'hF, 10'd0, '0, 1'b0, 4'h0),
                  32'h0, 1'b0, 32'h0, 1'b0);
    tbl[1]  = mkv(mk(10'd3, 32'hAABBCCDD, 1'b1, 4'b0101, 10'd0, '0, 1'b0, 4'h0),
                  32'h11BB33DD, 1'b1, 32'h0, 1'b0);
    tbl[2]  = mkv(mk(10'd5, 32'h000000AA, 1'b1, 4'b0001, 10'd5, 32'h0000BBCC, 1'b1, 4'b0011),
                  32'h0000BBAA, 1'b1, 32'h0000BBAA, 1'b1);
    tbl[3]  = mkv(mk(10'd5, '0, 1'b1, 4'h0, 10'd3, '0, 1'b1, 4'h0),
                  32'h0000BBAA, 1'b1, 32'h11BB33DD, 1'b1);
    tbl[4]  = mkv(mk(10'd1020, 32'hFFFFFFFF, 1'b0, 4'hF, 10'd0, '0, 1'b0, 4'h0),
                  32'h0000BBAA, 1'b0, 32'h11BB33DD, 1'b0);
    tbl[5]  = mkv(mk(10'd1020, '0, 1'b1, 4'h0, 10'd999, '0, 1'b1, 4'h0),
                  32'h0, 1'b1, 32'h0, 1'b1);
    tbl[6]  = mkv(mk(10'd0, '0, 1'b0, 4'h0, 10'd1023, 32'hFFFFFFFF, 1'b1, 4'hF),
                  32'h0, 1'b0, 32'h0, 1'b1);
    tbl[7]  = mkv(mk(10'd10, 32'h12345678, 1'b1, 4'b1010, 10'd10, '0, 1'b1, 4'h0),
                  32'h12005600, 1'b1, 32'h12005600, 1'b1);
    tbl[8]  = mkv(mk(10'd7, 32'hA1A2A3A4, 1'b1, 4'b0011, 10'd7, 32'hB1B2B3B4, 1'b1, 4'b0110),
                  32'h00B2A3A4, 1'b1, 32'h00B2A3A4, 1'b1);
    tbl[9]  = mkv(mk(10'd7, '0, 1'b0, 4'h0, 10'd10, '0, 1'b0, 4'h0),
                  32'h00B2A3A4, 1'b0, 32'h00B2A3A4, 1'b0);
    tbl[10] = mkv(mk(10'd3, '0, 1'b1, 4'h0, 10'd7, '0, 1'b1, 4'h0),
                  32'h11BB33DD, 1'b1, 32'h00B2A3A4, 1'b1);
    for (int i = 0; i < 11; i++)
      do_step(1, tbl[i].r, $sformatf("tbl%0d", i), 1'b1, tbl[i]);

    // Every in-range word must match the model after the out-of-range writes.
    for (int i = 0; i < 500; i++)
      do_step(1, mk(10'(2*i), '0, 1'b1, 4'h0, 10'(2*i+1), '0, 1'b1, 4'h0),
              "sweep", 1'b0, dummy);
    rnd_steps(1, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
